vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. It drives the hcount/vcount bus consumed by every pixel-drawing block (overlays, sprites, game-over screen). It samples their merged 24-bit rgb and registers it, together with the sync and blank signals, onto the board VGA DAC pins. It is the source end of the hcount/vcount -> rgb drawing interface.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/pix_clk_div.sv | 37 +++
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants for the VGA timing generator and its consumers.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;

   localparam int COUNT_W  = 10;

endpackage

// File: rtl/pix_clk_div.sv
// Divides the system clock down to the pixel rate: pix_en strobe plus a square DAC clock.
module pix_clk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   output logic pix_en,
   output logic vga_clk
);

   localparam int               DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;

   always_comb begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   // Strobe on the last phase so the first pixel advance lands CLK_DIV clocks after reset.
   assign pix_en  = (div_cnt_q == DIV_LAST);
   assign vga_clk = (div_cnt_q >= DIV_HALF);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync decode and the registered DAC output stage.
module vga_timing_gen #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int H_FP     = vga_pkg::H_FP,
   parameter int H_SYNC   = vga_pkg::H_SYNC,
   parameter int H_BP     = vga_pkg::H_BP,
   parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int V_FP     = vga_pkg::V_FP,
   parameter int V_SYNC   = vga_pkg::V_SYNC,
   parameter int V_BP     = vga_pkg::V_BP
) (
   input  logic        clk,
   input  logic        reset,
   output logic        pix_en,
   output logic [9:0]  hcount,
   output logic [9:0]  vcount,
   output logic        video_on,
   input  logic [23:0] rgb_in,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        hsync_n,
   output logic        vsync_n,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic        vga_clk,
   output logic        frame_start,
   output logic        line_start
);

   import vga_pkg::*;

   localparam logic [COUNT_W-1:0] H_VIS  = COUNT_W'(H_ACTIVE);
   localparam logic [COUNT_W-1:0] V_VIS  = COUNT_W'(V_ACTIVE);
   localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [COUNT_W-1:0] HS_LO  = COUNT_W'(H_ACTIVE + H_FP);
   localparam logic [COUNT_W-1:0] HS_HI  = COUNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COUNT_W-1:0] VS_LO  = COUNT_W'(V_ACTIVE + V_FP);
   localparam logic [COUNT_W-1:0] VS_HI  = COUNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [COUNT_W-1:0] hcount_q, hcount_d;
   logic [COUNT_W-1:0] vcount_q, vcount_d;
   logic [23:0]        rgb_q, rgb_d;
   logic               hsync_n_q, hsync_n_d;
   logic               vsync_n_q, vsync_n_d;
   logic               blank_n_q, blank_n_d;
   logic               hs_active, vs_active;

   pix_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk     (clk),
      .reset   (reset),
      .pix_en  (pix_en),
      .vga_clk (vga_clk)
   );

   assign video_on  = (hcount_q < H_VIS) && (vcount_q < V_VIS);
   assign hs_active = (hcount_q >= HS_LO) && (hcount_q < HS_HI);
   assign vs_active = (vcount_q >= VS_LO) && (vcount_q < VS_HI);

   always_comb begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      if (pix_en) begin
         if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + COUNT_W'(1);
         end else begin
            hcount_d = hcount_q + COUNT_W'(1);
         end
      end
   end

   // Output stage samples the same pixel the counters point at, so the DAC trails by one pixel.
   always_comb begin
      rgb_d     = rgb_q;
      hsync_n_d = hsync_n_q;
      vsync_n_d = vsync_n_q;
      blank_n_d = blank_n_q;
      if (pix_en) begin
         rgb_d     = video_on ? rgb_in : 24'h0;
         hsync_n_d = ~hs_active;
         vsync_n_d = ~vs_active;
         blank_n_d = video_on;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hcount_q  <= '0;
         vcount_q  <= '0;
         rgb_q     <= 24'h0;
         hsync_n_q <= 1'b1;
         vsync_n_q <= 1'b1;
         blank_n_q <= 1'b0;
      end else begin
         hcount_q  <= hcount_d;
         vcount_q  <= vcount_d;
         rgb_q     <= rgb_d;
         hsync_n_q <= hsync_n_d;
         vsync_n_q <= vsync_n_d;
         blank_n_q <= blank_n_d;
      end
   end

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign vga_r       = rgb_q[23:16];
   assign vga_g       = rgb_q[15:8];
   assign vga_b       = rgb_q[7:0];
   assign hsync_n     = hsync_n_q;
   assign vsync_n     = vsync_n_q;
   assign vga_blank_n = blank_n_q;
   assign vga_sync_n  = 1'b0;
   assign line_start  = pix_en && (hcount_q == '0);
   assign frame_start = pix_en && (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken raster checked pixel-by-pixel against a clock-count model,
// plus a full-size 640x480 instance checked over its first two lines.
module tb_vga_timing_gen;

  localparam int CLK_DIV = 2;
  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 3;
  localparam int VA = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT * CLK_DIV;
  localparam int T_H = HA + HF + 1;
  localparam int T_V = 3;
  localparam logic [26:0] RESET_DAC = {24'h0, 1'b1, 1'b1, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  logic f_reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scaled DUT ----------------
  logic        pix_en, video_on, hsync_n, vsync_n, vga_blank_n, vga_sync_n, vga_clk;
  logic        frame_start, line_start;
  logic [9:0]  hcount, vcount;
  logic [23:0] rgb_in;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        mode;
  logic        mode_req;

  assign rgb_in = mode ? {hcount[7:0], vcount[7:0], 8'h5A} : 24'hFFFFFF;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .rgb_in(rgb_in), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_clk(vga_clk), .frame_start(frame_start), .line_start(line_start)
  );

  // ---------------- full-size DUT ----------------
  logic        f_pix_en, f_video_on, f_hsync_n, f_vsync_n, f_blank_n, f_sync_n, f_vga_clk;
  logic        f_frame_start, f_line_start;
  logic [9:0]  f_hcount, f_vcount;
  logic [7:0]  f_r, f_g, f_b;

  vga_timing_gen u_full (
    .clk(clk), .reset(f_reset), .pix_en(f_pix_en), .hcount(f_hcount), .vcount(f_vcount),
    .video_on(f_video_on), .rgb_in(24'hFFFFFF), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .hsync_n(f_hsync_n), .vsync_n(f_vsync_n), .vga_blank_n(f_blank_n), .vga_sync_n(f_sync_n),
    .vga_clk(f_vga_clk), .frame_start(f_frame_start), .line_start(f_line_start)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [26:0] exp_q[$];
  int k;
  int last_ls, last_fs, hs_low, vs_low;
  logic last_ep;
  int last_h, last_v;
  logic full_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [26:0] exp_dac(input int h, input int v, input logic m);
    logic        vid;
    logic [23:0] c;
    logic        hs_n, vs_n;
    vid  = (h < HA) && (v < VA);
    c    = m ? {8'(h), 8'(v), 8'h5A} : 24'hFFFFFF;
    if (!vid) c = 24'h0;
    hs_n = !((h >= HA + HF) && (h < HA + HF + HS));
    vs_n = !((v >= VA + VF) && (v < VA + VF + VS));
    return {c, hs_n, vs_n, vid};
  endfunction

  task automatic clear_model();
    k       = 0;
    last_ls = -1;
    last_fs = -1;
    hs_low  = 0;
    vs_low  = 0;
    last_ep = 1'b0;
    last_h  = -1;
    last_v  = -1;
    exp_q.delete();
    exp_q.push_back(RESET_DAC);
  endtask

  task automatic check_reset_outputs(input string who);
    check({who, "_pix_en"},      pix_en, 0);
    check({who, "_hcount"},      hcount, 0);
    check({who, "_vcount"},      vcount, 0);
    check({who, "_rgb"},         {vga_r, vga_g, vga_b}, 0);
    check({who, "_hsync_n"},     hsync_n, 1);
    check({who, "_vsync_n"},     vsync_n, 1);
    check({who, "_blank_n"},     vga_blank_n, 0);
    check({who, "_sync_n"},      vga_sync_n, 0);
    check({who, "_vga_clk"},     vga_clk, 0);
    check({who, "_line_start"},  line_start, 0);
    check({who, "_frame_start"}, frame_start, 0);
  endtask

  // Called at every falling edge; k = rising edges seen since reset was released.
  task automatic monitor();
    int   p, h, v;
    logic ep;
    mode = mode_req;
    ep = (k % CLK_DIV) == (CLK_DIV - 1);
    p  = k / CLK_DIV;
    h  = p % HT;
    v  = (p / HT) % VT;
    check("pix_en", pix_en, ep);
    check("vga_clk", vga_clk, (k % CLK_DIV) >= (CLK_DIV / 2));
    check("hcount", hcount, h);
    check("vcount", vcount, v);
    check("video_on", video_on, (h < HA) && (v < VA));
    check("line_start", line_start, ep && (h == 0));
    check("frame_start", frame_start, ep && (h == 0) && (v == 0));
    if (line_start) begin
      if (last_ls >= 0) check("line_period", k - last_ls, HT * CLK_DIV);
      last_ls = k;
    end
    if (frame_start) begin
      if (last_fs >= 0) check("frame_period", k - last_fs, FRAME_CLKS);
      last_fs = k;
    end
    if (!hsync_n) hs_low++;
    else if (hs_low != 0) begin
      check("hsync_len", hs_low, HS * CLK_DIV);
      hs_low = 0;
    end
    if (!vsync_n) vs_low++;
    else if (vs_low != 0) begin
      check("vsync_len", vs_low, VS * HT * CLK_DIV);
      vs_low = 0;
    end
    if (ep) begin
      if (exp_q.size() == 0) check("dac_queue_empty", 1, 0);
      else check("dac", {vga_r, vga_g, vga_b, hsync_n, vsync_n, vga_blank_n}, exp_q.pop_front());
      exp_q.push_back(exp_dac(h, v, mode));
    end
    last_ep = ep;
    last_h  = h;
    last_v  = v;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      monitor();
    end
  endtask

  task automatic run_until_target(input int budget);
    int i;
    i = 0;
    while (!(last_ep && last_h == T_H && last_v == T_V) && i < budget) begin
      @(negedge clk);
      k++;
      monitor();
      i++;
    end
    check("reset_target_reached", (last_ep && last_h == T_H && last_v == T_V), 1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    reset    = 1'b1;
    mode     = 1'b0;
    mode_req = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("por");
    clear_model();
    reset = 1'b0;

    run(2 * FRAME_CLKS);
    mode_req = 1'b1;
    run(FRAME_CLKS + 100);

    // Hit reset on a strobe inside hsync of an active line.
    run_until_target(2 * FRAME_CLKS);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid");
    clear_model();
    reset = 1'b0;
    run(2 * FRAME_CLKS + 10);

    wait (full_done);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- full-size line checks ----------------
  initial begin
    int f_last_ls, f_hs_low, f_last_h, f_last_v;
    logic f_hs_prev, f_blank_prev;
    f_reset      = 1'b1;
    f_last_ls    = -1;
    f_hs_low     = 0;
    f_last_h     = -1;
    f_last_v     = -1;
    f_hs_prev    = 1'b1;
    f_blank_prev = 1'b0;
    repeat (3) @(negedge clk);
    f_reset = 1'b0;
    for (int i = 1; i <= 3400; i++) begin
      @(negedge clk);
      if (f_line_start) begin
        if (f_last_ls >= 0) check("full_line_period", i - f_last_ls, 1600);
        f_last_ls = i;
      end
      if (!f_hsync_n) f_hs_low++;
      else if (f_hs_low != 0) begin
        check("full_hsync_len", f_hs_low, 192);
        f_hs_low = 0;
      end
      if (f_hs_prev && !f_hsync_n) check("full_hsync_fall_h", f_last_h, 656);
      if (f_blank_prev && !f_blank_n) begin
        check("full_blank_fall_h", f_last_h, 640);
        check("full_rgb_blank", {f_r, f_g, f_b}, 0);
      end
      if (f_blank_n) check("full_rgb_active", {f_r, f_g, f_b}, 24'hFFFFFF);
      check("full_vsync_n", f_vsync_n, 1);
      if (f_pix_en) begin
        if (f_last_h == 799) begin
          check("full_hwrap_h", f_hcount, 0);
          check("full_hwrap_v", f_vcount, f_last_v + 1);
        end
        f_last_h = f_hcount;
        f_last_v = f_vcount;
      end
      f_hs_prev    = f_hsync_n;
      f_blank_prev = f_blank_n;
    end
    full_done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got=%0d tests expected=finish", n_tests);
    $fatal(1, "timeout");
  end

endmodule
